ccff_bitstream_loader: RTL and testbench
========================================

CCFF_BITSTREAM_LOADER -- requirements
Module: ccff_bitstream_loader

Interface
REQ-001 Parameter CHAIN_LEN, default 20, SHALL set the number of configuration bits shifted into the downstream ccff_head chain per load (range 1..65535).
REQ-002 Parameter WORD_W, default 8, SHALL set the width of the bitstream input word.
REQ-003 The block SHALL use one clock, prog_clk; prog_reset SHALL be asynchronous and active-high.
REQ-004 prog_clk  input  1  programming clock; all state changes on its rising edge.
REQ-005 prog_reset  input  1  asynchronous, active-high reset.
REQ-006 start  input  1  single-cycle load request.
REQ-007 abort  input  1  cancels any load in progress.
REQ-008 bs_data  input  WORD_W  bitstream word, LSB shifted first.
REQ-009 bs_valid  input  1  bs_data valid.
REQ-010 bs_ready  output  1  loader accepts a word this cycle.
REQ-011 ccff_head  output  1  serial configuration bit to the chain head.
REQ-012 ccff_shift_en  output  1  chain shift enable; the chain SHALL hold when low.
REQ-013 busy  output  1  load in progress.
REQ-014 done  output  1  full chain loaded.
REQ-015 bit_count  output  16  number of bits shifted in the current or last load.

Function
REQ-016 The FSM SHALL have the states IDLE, LOAD, SHIFT and DONE.
REQ-017 In IDLE or DONE, start with abort low SHALL clear bit_count and done, and enter LOAD on the next edge.
REQ-018 In LOAD, bs_ready SHALL be 1; in all other states it SHALL be 0.
REQ-019 A handshake (bs_valid and bs_ready) SHALL load a shift register with bs_data and a per-word bit count k = min(WORD_W, CHAIN_LEN - bit_count), then enter SHIFT.
REQ-020 In SHIFT, ccff_head and ccff_shift_en SHALL be registered outputs. For a handshake at cycle t, they SHALL carry bit i of the word with shift_en=1 during cycle t+1+i, for i = 0..k-1.
REQ-021 On each SHIFT cycle, bit_count SHALL increment by 1 and the shift register SHALL shift right by one.
REQ-022 After bit k-1 of a word: if bit_count equals CHAIN_LEN the FSM SHALL enter DONE, else LOAD. Word bits beyond k SHALL be discarded.
REQ-023 In LOAD, IDLE and DONE, ccff_shift_en SHALL be 0 and ccff_head SHALL hold its last value. One bubble per word is permitted.
REQ-024 In LOAD with bs_valid low, the FSM SHALL wait indefinitely with no timeout.
REQ-025 busy SHALL be 1 exactly in LOAD and SHIFT.
REQ-026 done SHALL be 1 only in DONE and SHALL stay 1 until the next accepted start or a reset.
REQ-027 start while busy SHALL be ignored.
REQ-028 abort in any state SHALL move the FSM to IDLE on the next edge, force ccff_shift_en to 0, clear done and keep bit_count. abort SHALL win over a simultaneous start or handshake.
REQ-029 bit_count SHALL never exceed CHAIN_LEN.

Reset
REQ-030 Reset values SHALL be: state IDLE, bs_ready 0, ccff_head 0, ccff_shift_en 0, busy 0, done 0, bit_count 0, shift register 0.
REQ-031 A reset asserted mid-load SHALL drop ccff_shift_en asynchronously. The next load SHALL require a new start.

Structure
REQ-032 The package ccff_loader_pkg SHALL hold the FSM state type, the WORD_W default and the bit_count width constant.
REQ-033 The block SHALL be a single module with no sub-module.

Verification
REQ-034 Normal load: CHAIN_LEN=20, start, then words 0xA5, 0x3C, 0x0F supplied with no gaps. Required response: ccff_head under shift_en = 1,0,1,0,0,1,0,1, 0,0,1,1,1,1,0,0, 1,1,1,1; exactly 20 shift_en cycles; done=1; bit_count=20.
REQ-035 Backpressure: bs_valid held low for 5 cycles between words. Required response: shift_en=0 and ccff_head held for those 5 cycles; the serial sequence is identical to REQ-034.
REQ-036 Abort: abort after 10 shifted bits, asserted together with bs_valid. Required response: IDLE next cycle, no further shift_en, done=0, bit_count=10, bs_ready=0.
REQ-037 Reset mid-shift: prog_reset asserted during SHIFT. Required response: all outputs at their reset values immediately; a new start and load reproduces REQ-034.
REQ-038 Start while busy: a second start during SHIFT. Required response: ignored, with a bit-exact REQ-034 result. A start in DONE restarts with bit_count cleared.
REQ-039 Odd length: CHAIN_LEN=1, one word 0xFE. Required response: exactly one shift_en cycle with ccff_head=0, then done.

Source files
------------

// File: rtl/ccff_loader_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : ccff_loader_pkg
//  Description : Shared types and constants for the configuration-chain
//                bitstream loader: FSM state type, default bitstream word
//                width and the width of the bit counter.
//  Revision    : 1.0 - initial release
// ============================================================================
package ccff_loader_pkg;

    localparam int WORD_W_DEFAULT = 8;
    localparam int BIT_COUNT_W    = 16;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_LOAD  = 2'd1,
        ST_SHIFT = 2'd2,
        ST_DONE  = 2'd3
    } state_t;

endpackage : ccff_loader_pkg
`default_nettype wire

// File: rtl/ccff_bitstream_loader.sv
`default_nettype none
// ============================================================================
//  Module      : ccff_bitstream_loader
//  Description : Takes bitstream words over a valid/ready handshake and shifts
//                them LSB-first into a configuration flip-flop chain until
//                CHAIN_LEN bits have been loaded.
//  Ports       : prog_clk      - programming clock (rising edge)
//                prog_reset    - asynchronous active-high reset
//                start         - single-cycle load request
//                abort         - cancel the current load, return to idle
//                bs_data       - bitstream word, LSB shifted first
//                bs_valid      - bs_data is valid
//                bs_ready      - loader accepts a word this cycle
//                ccff_head     - serial bit to the chain head (registered)
//                ccff_shift_en - chain shift enable (registered)
//                busy          - load in progress
//                done          - chain fully loaded
//                bit_count     - bits shifted in the current / last load
//  Revision    : 1.0 - initial release
// ============================================================================
module ccff_bitstream_loader
    import ccff_loader_pkg::*;
#(
    parameter int CHAIN_LEN = 20,
    parameter int WORD_W    = WORD_W_DEFAULT
) (
    input  logic                   prog_clk,
    input  logic                   prog_reset,
    input  logic                   start,
    input  logic                   abort,
    input  logic [WORD_W-1:0]      bs_data,
    input  logic                   bs_valid,
    output logic                   bs_ready,
    output logic                   ccff_head,
    output logic                   ccff_shift_en,
    output logic                   busy,
    output logic                   done,
    output logic [BIT_COUNT_W-1:0] bit_count
);

    localparam logic [BIT_COUNT_W-1:0] c_CHAIN_LEN = BIT_COUNT_W'(CHAIN_LEN);
    localparam logic [BIT_COUNT_W-1:0] c_WORD_W    = BIT_COUNT_W'(WORD_W);

    state_t                 state_q,     state_d;
    logic [WORD_W-1:0]      sr_q,        sr_d;
    logic [BIT_COUNT_W-1:0] rem_q,       rem_d;       // bits of the word still to present after the current one
    logic [BIT_COUNT_W-1:0] bit_count_q, bit_count_d;
    logic                   head_q,      head_d;
    logic                   shift_en_q,  shift_en_d;

    logic [BIT_COUNT_W-1:0] w_room;                   // chain positions not yet filled
    logic [BIT_COUNT_W-1:0] w_k;                      // bits of this word that will be used

    always_ff @(posedge prog_clk or posedge prog_reset) begin
        if (prog_reset) begin
            state_q     <= ST_IDLE;
            sr_q        <= '0;
            rem_q       <= '0;
            bit_count_q <= '0;
            head_q      <= 1'b0;
            shift_en_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            sr_q        <= sr_d;
            rem_q       <= rem_d;
            bit_count_q <= bit_count_d;
            head_q      <= head_d;
            shift_en_q  <= shift_en_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        sr_d        = sr_q;
        rem_d       = rem_q;
        bit_count_d = bit_count_q;
        head_d      = head_q;
        shift_en_d  = 1'b0;

        w_room = c_CHAIN_LEN - bit_count_q;
        w_k    = (w_room > c_WORD_W) ? c_WORD_W : w_room;

        if (abort) begin
            state_d = ST_IDLE;
        end else begin
            case (state_q)
                ST_IDLE, ST_DONE: begin
                    if (start) begin
                        bit_count_d = '0;
                        state_d     = ST_LOAD;
                    end
                end
                ST_LOAD: begin
                    // Bit 0 is registered onto the head at the handshake edge so it
                    // is on the chain during the first SHIFT cycle; the rest waits
                    // in the shift register.
                    if (bs_valid) begin
                        head_d     = bs_data[0];
                        shift_en_d = 1'b1;
                        sr_d       = bs_data >> 1;
                        rem_d      = w_k - 1'b1;
                        state_d    = ST_SHIFT;
                    end
                end
                ST_SHIFT: begin
                    bit_count_d = bit_count_q + 1'b1;
                    sr_d        = sr_q >> 1;
                    if (rem_q == '0) begin
                        // Last used bit of this word; any leftover bits are dropped.
                        state_d = (bit_count_d == c_CHAIN_LEN) ? ST_DONE : ST_LOAD;
                    end else begin
                        head_d     = sr_q[0];
                        shift_en_d = 1'b1;
                        rem_d      = rem_q - 1'b1;
                    end
                end
                default: state_d = ST_IDLE;
            endcase
        end
    end

    assign bs_ready      = (state_q == ST_LOAD);
    assign busy          = (state_q == ST_LOAD) || (state_q == ST_SHIFT);
    assign done          = (state_q == ST_DONE);
    assign ccff_head     = head_q;
    assign ccff_shift_en = shift_en_q;
    assign bit_count     = bit_count_q;

endmodule : ccff_bitstream_loader
`default_nettype wire

// File: tb/tb_ccff_bitstream_loader.sv
`default_nettype none
// ============================================================================
//  Module      : tb_ccff_bitstream_loader
//  Description : Self-checking bench for ccff_bitstream_loader. A 20-bit chain
//                instance covers normal, backpressure, abort, reset and
//                restart behaviour plus random loads; a 1-bit chain instance
//                covers the shortest chain.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_ccff_bitstream_loader;

    logic        prog_clk = 1'b0;
    logic        prog_reset;
    logic        start;
    logic        abort;
    logic [7:0]  bs_data;
    logic        bs_valid;

    logic        bs_ready, ccff_head, ccff_shift_en, busy, done;
    logic [15:0] bit_count;
    logic        bs_ready1, ccff_head1, ccff_shift_en1, busy1, done1;
    logic [15:0] bit_count1;

    int checks   = 0;
    int failures = 0;

    logic [7:0] words_q[$];
    bit         exp_q[$];
    bit         got_q[$];
    bit         got1_q[$];
    int         nsent;

    ccff_bitstream_loader #(.CHAIN_LEN(20), .WORD_W(8)) dut (
        .prog_clk(prog_clk), .prog_reset(prog_reset), .start(start), .abort(abort),
        .bs_data(bs_data), .bs_valid(bs_valid), .bs_ready(bs_ready),
        .ccff_head(ccff_head), .ccff_shift_en(ccff_shift_en), .busy(busy),
        .done(done), .bit_count(bit_count)
    );

    ccff_bitstream_loader #(.CHAIN_LEN(1), .WORD_W(8)) dut1 (
        .prog_clk(prog_clk), .prog_reset(prog_reset), .start(start), .abort(abort),
        .bs_data(bs_data), .bs_valid(bs_valid), .bs_ready(bs_ready1),
        .ccff_head(ccff_head1), .ccff_shift_en(ccff_shift_en1), .busy(busy1),
        .done(done1), .bit_count(bit_count1)
    );

    always #5 prog_clk = ~prog_clk;

    // Capture what the chain actually receives.
    always @(negedge prog_clk) begin
        if (ccff_shift_en)  got_q.push_back(ccff_head);
        if (ccff_shift_en1) got1_q.push_back(ccff_head1);
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic timeout_fail(input string tag);
        checks++;
        failures++;
        $display("FAIL %s observed=timeout expected=event", tag);
    endtask

    // Chain contents: word bits LSB first, concatenated, cut at the chain length.
    function automatic void build_exp(input int cl);
        exp_q.delete();
        foreach (words_q[w])
            for (int i = 0; i < 8; i++)
                if (exp_q.size() < cl) exp_q.push_back(words_q[w][i]);
    endfunction

    task automatic check_reset_outputs(input string tag);
        chk({tag, "_ready"},  bs_ready, 0);
        chk({tag, "_head"},   ccff_head, 0);
        chk({tag, "_sen"},    ccff_shift_en, 0);
        chk({tag, "_busy"},   busy, 0);
        chk({tag, "_done"},   done, 0);
        chk({tag, "_bitcnt"}, bit_count, 0);
    endtask

    task automatic do_start();
        @(negedge prog_clk);
        start = 1'b1;
        @(posedge prog_clk);
        #1 start = 1'b0;
        nsent = 0;
        got_q.delete();
        got1_q.delete();
    endtask

    task automatic wait_ready(input string tag);
        int n = 0;
        @(negedge prog_clk);
        while (!bs_ready && n < 200) begin
            @(negedge prog_clk);
            n++;
        end
        if (n >= 200) timeout_fail({tag, "_ready_wait"});
    endtask

    task automatic send_word(input logic [7:0] d, input int gap, input string tag);
        int held;
        wait_ready(tag);
        held = (8 * nsent < exp_q.size()) ? 8 * nsent : exp_q.size();
        for (int g = 0; g < gap; g++) begin
            chk({tag, "_gap_sen"}, ccff_shift_en, 0);
            if (held > 0) chk({tag, "_gap_head"}, ccff_head, exp_q[held-1]);
            @(negedge prog_clk);
        end
        bs_valid = 1'b1;
        bs_data  = d;
        @(posedge prog_clk);
        #1 bs_valid = 1'b0;
        bs_data = 8'($urandom);
        nsent++;
    endtask

    task automatic wait_done(input string tag);
        int n = 0;
        while (!done && n < 200) begin
            @(negedge prog_clk);
            n++;
        end
        if (n >= 200) timeout_fail({tag, "_done_wait"});
        @(negedge prog_clk);
    endtask

    task automatic check_stream(input string tag);
        chk({tag, "_nbits"}, got_q.size(), exp_q.size());
        for (int i = 0; i < exp_q.size(); i++)
            if (i < got_q.size()) chk($sformatf("%s_bit%0d", tag, i), got_q[i], exp_q[i]);
        chk({tag, "_done"},   done, 1);
        chk({tag, "_busy"},   busy, 0);
        chk({tag, "_bitcnt"}, bit_count, 20);
    endtask

    task automatic run_load(input int gap, input string tag);
        build_exp(20);
        do_start();
        foreach (words_q[w]) send_word(words_q[w], (w == 0) ? 0 : gap, tag);
        wait_done(tag);
        check_stream(tag);
    endtask

    initial begin
        int n;
        int snap;
        prog_reset = 1'b1;
        start      = 1'b0;
        abort      = 1'b0;
        bs_valid   = 1'b0;
        bs_data    = 8'h00;
        nsent      = 0;
        #12;
        check_reset_outputs("reset");
        @(negedge prog_clk);
        prog_reset = 1'b0;

        // Normal load, words back to back.
        words_q = '{8'hA5, 8'h3C, 8'h0F};
        run_load(0, "normal");

        // Backpressure: 5 idle cycles between words.
        run_load(5, "bp");

        // Second start while shifting is ignored.
        build_exp(20);
        do_start();
        send_word(8'hA5, 0, "busystart");
        @(negedge prog_clk);
        start = 1'b1;
        @(posedge prog_clk);
        #1 start = 1'b0;
        send_word(8'h3C, 0, "busystart");
        send_word(8'h0F, 0, "busystart");
        wait_done("busystart");
        check_stream("busystart");

        // Start from DONE restarts with a cleared count.
        @(negedge prog_clk);
        start = 1'b1;
        @(posedge prog_clk);
        #1 start = 1'b0;
        chk("restart_bitcnt", bit_count, 0);
        chk("restart_done",   done, 0);
        chk("restart_busy",   busy, 1);
        chk("restart_ready",  bs_ready, 1);
        @(negedge prog_clk);
        abort = 1'b1;
        @(posedge prog_clk);
        #1 abort = 1'b0;
        chk("restart_abort_busy", busy, 0);

        // Abort after 10 shifted bits, together with bs_valid.
        build_exp(20);
        do_start();
        send_word(8'hA5, 0, "abort");
        send_word(8'h3C, 0, "abort");
        n = 0;
        @(negedge prog_clk);
        while (bit_count != 16'd10 && n < 50) begin
            @(negedge prog_clk);
            n++;
        end
        if (n >= 50) timeout_fail("abort_bitcnt_wait");
        abort    = 1'b1;
        bs_valid = 1'b1;
        @(posedge prog_clk);
        #1 abort = 1'b0;
        bs_valid = 1'b0;
        snap = got_q.size();
        chk("abort_busy",   busy, 0);
        chk("abort_sen",    ccff_shift_en, 0);
        chk("abort_done",   done, 0);
        chk("abort_bitcnt", bit_count, 10);
        chk("abort_ready",  bs_ready, 0);
        repeat (5) @(negedge prog_clk);
        chk("abort_no_more_shift", got_q.size(), snap);
        chk("abort_bitcnt_hold",   bit_count, 10);
        chk("abort_idle_busy",     busy, 0);

        // Reset in the middle of shifting a word.
        do_start();
        send_word(8'hA5, 0, "rst");
        @(negedge prog_clk);
        @(negedge prog_clk);
        chk("rst_pre_sen", ccff_shift_en, 1);
        #1 prog_reset = 1'b1;
        #1 check_reset_outputs("rst_mid");
        @(negedge prog_clk);
        prog_reset = 1'b0;
        repeat (3) @(negedge prog_clk);
        chk("rst_needs_start_busy", busy, 0);
        chk("rst_needs_start_sen",  ccff_shift_en, 0);
        run_load(0, "rst_reload");

        // Random words and gaps against the model.
        for (int r = 0; r < 4; r++) begin
            words_q = '{8'($urandom), 8'($urandom), 8'($urandom)};
            run_load($urandom_range(0, 3), $sformatf("rand%0d", r));
        end

        // One-bit chain takes a single bit of 0xFE.
        @(negedge prog_clk);
        prog_reset = 1'b1;
        @(negedge prog_clk);
        prog_reset = 1'b0;
        words_q = '{8'hFE};
        build_exp(20);
        do_start();
        send_word(8'hFE, 0, "len1");
        n = 0;
        while (!done1 && n < 50) begin
            @(negedge prog_clk);
            n++;
        end
        if (n >= 50) timeout_fail("len1_done_wait");
        repeat (3) @(negedge prog_clk);
        chk("len1_nbits", got1_q.size(), 1);
        if (got1_q.size() > 0) chk("len1_head", got1_q[0], 0);
        chk("len1_done",   done1, 1);
        chk("len1_bitcnt", bit_count1, 1);
        chk("len1_busy",   busy1, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule : tb_ccff_bitstream_loader
`default_nettype wire
